// File: rtl/riscv_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// riscv_pkg : shared widths, reset PC and fetch-entry record for the front end
// Rev 1.0
// ---------------------------------------------------------------------------
package riscv_pkg;

  localparam int XLEN    = 32;
  localparam int ILEN    = 32;
  localparam int IMEM_AW = 10;
  localparam int unsigned RESET_PC = 0;
  localparam int PC_STEP = 4;

  typedef struct packed {
    logic [IMEM_AW-1:0] pc;
    logic [ILEN-1:0]    instr;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_fifo : DEPTH-entry synchronous FIFO of fetch entries with flush
// Rev 1.0
// ---------------------------------------------------------------------------
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter type T     = fetch_entry_t,
  parameter int  DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  T              wdata_i,
  output T              rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  T              mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;

  assign rdata_o = mem_q[rd_q];
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= wdata_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop_i) rd_q <= rd_q + 1'b1;
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop_i && !flush_i && empty_o));

endmodule
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// instruction_fetch : PC, imem request, fetch FIFO and redirect flush
// Rev 1.0
// ---------------------------------------------------------------------------
module instruction_fetch #(
  parameter int          N        = riscv_pkg::ILEN,
  parameter int          A        = riscv_pkg::IMEM_AW,
  parameter int          DEPTH    = 2,
  parameter int unsigned RESET_PC = riscv_pkg::RESET_PC
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         fetch_en,
  output logic [A-1:0] imem_addr,
  input  logic [N-1:0] imem_data,
  input  logic         redirect_valid,
  input  logic [A-1:0] redirect_pc,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_instr,
  output logic [A-1:0] out_pc
);

  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [A-1:0] pc;
    logic [N-1:0] instr;
  } entry_t;

  logic [A-1:0]  pc_q, pc_d;
  entry_t        wr_entry, head;
  logic          full, empty, deq, enq, space;
  logic [CW-1:0] count;

  assign imem_addr = pc_q;
  assign out_valid = ~empty & ~redirect_valid;
  assign deq       = out_valid & out_ready;
  assign space     = ~full | deq;
  assign enq       = fetch_en & space & ~redirect_valid;
  assign wr_entry  = '{pc: pc_q, instr: imem_data};
  assign out_instr = head.instr;
  assign out_pc    = head.pc;

  // Redirect wins over sequential fetch; targets are forced word aligned.
  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) pc_d = redirect_pc & ~A'(3);
    else if (enq)       pc_d = pc_q + A'(riscv_pkg::PC_STEP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= A'(RESET_PC);
    else        pc_q <= pc_d;
  end

  fetch_fifo #(
    .T     (entry_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (enq),
    .pop_i   (deq),
    .flush_i (redirect_valid),
    .wdata_i (wr_entry),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
    count <= CW'(DEPTH));

endmodule
`default_nettype wire

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Initiator side of the instruction-memory read interface. Holds the program counter, drives a byte address to the combinational instruction memory, and captures the returned word together with its PC into a small FIFO. Presents fetched instructions to decode over a valid/ready handshake. Accepts redirects (branch/jump target) from execute, which flush all buffered wrong-path instructions.

Parameters:
N, 32, instruction/data word width in bits
A, 10, byte-address width driven to instruction memory; PC width
DEPTH, 2, fetch FIFO entries (power of two, >=2)
RESET_PC, 0, PC value loaded on reset (word aligned)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
fetch_en  input  1  1 = fetch permitted this cycle; 0 = PC frozen, no enqueue
imem_addr  output  A  byte address to instruction memory; equals pc
imem_data  input  N  instruction word at imem_addr, valid same cycle (combinational memory)
redirect_valid  input  1  execute requests PC change, flushes FIFO
redirect_pc  input  A  redirect target byte address
out_valid  output  1  head FIFO entry available to decode
out_ready  input  1  decode accepts head entry
out_instr  output  N  instruction of head entry
out_pc  output  A  PC of head entry

Behaviour:
- Reset (async assert, sync-safe deassert): pc=RESET_PC, FIFO count=0, rd/wr pointers=0; out_valid=0, out_instr=0, out_pc=0, imem_addr=RESET_PC.
- imem_addr = pc at all times (no register between pc and port).
- deq = out_valid & out_ready.
- space = (count < DEPTH) | deq.
- enq = fetch_en & space & ~redirect_valid; on enq write {pc, imem_data} at wr pointer, pc <= pc + 4.
- PC arithmetic modulo 2^A: pc = 2^A-4 increments to 0; no error flag.
- Redirect (highest priority): pc <= {redirect_pc[A-1:2], 2'b00} (low bits forced zero); count, rd and wr pointers cleared next cycle; no enqueue that cycle.
- out_valid = (count != 0) & ~redirect_valid; a head entry is never accepted in the redirect cycle.
- out_instr/out_pc driven from head entry; when count==0 they hold the last-read entry contents (don't-care, not checked).
- Latency: instruction at pc visible on out_* one cycle after fetch (registered FIFO); first instruction appears cycle 1 after reset release when fetch_en=1.
- Throughput: one instruction per cycle sustained when out_ready=1.
- Full FIFO with out_ready=0: no enqueue, pc held, imem_addr stable.
- Full FIFO with out_ready=1: enqueue and dequeue the same cycle; count unchanged.
- Empty FIFO, enq and no deq: count=1 next cycle.
- fetch_en=0: pc held, no enqueue; draining via deq continues.
- Simultaneous redirect and fetch_en=0: redirect still applied.
- Count never exceeds DEPTH and never underflows (assertion).
- Reset mid-operation: all state returns to reset values immediately; buffered entries discarded.

Decomposition:
- Shared package riscv_pkg: XLEN/ILEN (32), IMEM_AW (10), RESET_PC, PC_STEP (4), typedef fetch_entry_t {pc, instr}.
- One sub-module, fetch_fifo: DEPTH-entry synchronous FIFO of fetch_entry_t with push, pop, flush, full/empty, count; clk/rst_n. instruction_fetch holds the pc register, enq/deq logic and redirect logic.

Test Plan:
- Reset then fetch_en=1, out_ready=1, memory word k = 0x1000_0000+k -> out_pc 0x000,0x004,0x008 on consecutive cycles from cycle 1; out_instr 0x1000_0000, 0x1000_0001, 0x1000_0002.
- out_ready=0 from cycle 1 -> FIFO fills after 2 enqueues, imem_addr frozen at 0x008, out_pc stays 0x000; release out_ready -> 0x000, 0x004, 0x008 in order, no gaps or duplicates.
- Redirect to 0x100 with 2 entries buffered -> out_valid=0 that cycle and the next; next out_pc=0x100, stale 0x004/0x008 never accepted.
- redirect_pc=0x203 -> fetch resumes at 0x200.
- PC at 0x3FC, continuous fetch -> next out_pc after 0x3FC is 0x000.
- rst_n pulsed low asynchronously mid-burst (between edges) -> out_valid=0 and imem_addr=RESET_PC immediately; after release, fetch restarts at RESET_PC.
